// File: rtl/line_burst_adaptor.sv
// Converts cache line requests into four-beat memory bursts, assembling read fills and serialising writebacks.
// Optional build macro LINE_BURST_TIMEOUT_EN adds an 8-bit inactivity timeout that aborts a stalled burst.
module line_burst_adaptor #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read_i,
  input  logic              write_i,
  input  logic [31:0]       address_i,
  input  logic [LINE_W-1:0] line_i,
  output logic [LINE_W-1:0] line_o,
  output logic              resp_o,
  output logic              read_o,
  output logic              write_o,
  output logic [31:0]       address_o,
  output logic [BEAT_W-1:0] burst_o,
  input  logic [BEAT_W-1:0] burst_i,
  input  logic              resp_i,
  output logic              err_o
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t            state;
  logic [1:0]        count;
  logic [1:0]        cnt_nx;
  logic [LINE_W-1:0] wline;
  logic              last_beat;
  logic              tmo;

  assign cnt_nx    = count + 2'd1;
  assign last_beat = resp_i && (count == 2'd3);

`ifdef LINE_BURST_TIMEOUT_EN
  logic [7:0] tcnt;
  // Abort on the 255th consecutive cycle without an acknowledge.
  assign tmo = !resp_i && (tcnt == 8'd254);
`else
  assign tmo   = 1'b0;
  assign err_o = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= 2'd0;
      line_o    <= '0;
      wline     <= '0;
      address_o <= '0;
      read_o    <= 1'b0;
      write_o   <= 1'b0;
      resp_o    <= 1'b0;
      burst_o   <= '0;
`ifdef LINE_BURST_TIMEOUT_EN
      err_o     <= 1'b0;
      tcnt      <= 8'd0;
`endif
    end else begin
      resp_o <= 1'b0;
`ifdef LINE_BURST_TIMEOUT_EN
      err_o  <= 1'b0;
      if (state == IDLE) begin
        tcnt <= 8'd0;
      end else if (state == RD || state == WR) begin
        if (resp_i || tmo) tcnt <= 8'd0;
        else               tcnt <= tcnt + 8'd1;
        if (tmo) err_o <= 1'b1;
      end
`endif
      case (state)
        IDLE: begin
          // Write has priority; reads never disturb the writeback buffer.
          if (write_i) begin
            state     <= WR;
            write_o   <= 1'b1;
            address_o <= {address_i[31:5], 5'b0};
            wline     <= line_i;
            burst_o   <= line_i[BEAT_W-1:0];
            count     <= 2'd0;
          end else if (read_i) begin
            state     <= RD;
            read_o    <= 1'b1;
            address_o <= {address_i[31:5], 5'b0};
            count     <= 2'd0;
          end
        end
        RD: begin
          if (resp_i) begin
            line_o[count*BEAT_W +: BEAT_W] <= burst_i;
            count <= cnt_nx;
          end
          if (last_beat || tmo) begin
            state  <= DONE;
            read_o <= 1'b0;
            resp_o <= 1'b1;
          end
        end
        WR: begin
          if (resp_i) begin
            count   <= cnt_nx;
            burst_o <= wline[cnt_nx*BEAT_W +: BEAT_W];
          end
          if (last_beat || tmo) begin
            state   <= DONE;
            write_o <= 1'b0;
            resp_o  <= 1'b1;
            burst_o <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_burst_adaptor.sv
// Directed bench for line_burst_adaptor: read fill, gapped writeback, priority, async reset, stall behaviour.
module tb_line_burst_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic         read_i, write_i;
  logic [31:0]  address_i;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic         resp_o, read_o, write_o;
  logic [31:0]  address_o;
  logic [63:0]  burst_o;
  logic [63:0]  burst_i;
  logic         resp_i;
  logic         err_o;

  int n_assert = 0;
  int n_fail   = 0;

  logic [255:0] exp_line_q[$];
  logic [63:0]  exp_beat_q[$];

  always #5 clk = ~clk;

  line_burst_adaptor #(.LINE_W(256), .BEAT_W(64)) dut (
    .clk(clk), .rst(rst), .read_i(read_i), .write_i(write_i),
    .address_i(address_i), .line_i(line_i), .line_o(line_o),
    .resp_o(resp_o), .read_o(read_o), .write_o(write_o),
    .address_o(address_o), .burst_o(burst_o), .burst_i(burst_i),
    .resp_i(resp_i), .err_o(err_o)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".read_o"},    256'(read_o),    256'd0);
    chk({tag, ".write_o"},   256'(write_o),   256'd0);
    chk({tag, ".resp_o"},    256'(resp_o),    256'd0);
    chk({tag, ".err_o"},     256'(err_o),     256'd0);
    chk({tag, ".address_o"}, 256'(address_o), 256'd0);
    chk({tag, ".burst_o"},   256'(burst_o),   256'd0);
    chk({tag, ".line_o"},    line_o,          256'd0);
  endtask

  initial begin
    logic [63:0]  beats[4];
    logic [63:0]  cur;
    logic         pat[6];
    logic [255:0] held;
    int           k;
    bit           seen;

    rst = 1'b1; read_i = 0; write_i = 0; address_i = '0; line_i = '0;
    burst_i = '0; resp_i = 0;
    repeat (2) @(negedge clk);
    chk_idle_outputs("reset");
    rst = 1'b0;

    // Read fill
    beats[0] = 64'h1111_1111_1111_1111; beats[1] = 64'h2222_2222_2222_2222;
    beats[2] = 64'h3333_3333_3333_3333; beats[3] = 64'h4444_4444_4444_4444;
    address_i = 32'h0000_1234; read_i = 1'b1;
    exp_line_q.push_back({beats[3], beats[2], beats[1], beats[0]});
    @(negedge clk);
    chk("rd.read_o", 256'(read_o), 256'd1);
    chk("rd.write_o", 256'(write_o), 256'd0);
    chk("rd.address_o", 256'(address_o), 256'h1220);
    for (int b = 0; b < 4; b++) begin
      resp_i = 1'b1; burst_i = beats[b];
      @(negedge clk);
      if (b < 3) chk("rd.resp_early", 256'(resp_o), 256'd0);
    end
    resp_i = 1'b0; burst_i = '0;
    chk("rd.resp_o", 256'(resp_o), 256'd1);
    chk("rd.read_o_drop", 256'(read_o), 256'd0);
    chk("rd.line_o", line_o, exp_line_q.pop_front());
    held = line_o;
    // Keep read_i high through DONE: a new transaction must follow.
    address_i = 32'h0000_0040;
    @(negedge clk);
    chk("b2b.resp_pulse", 256'(resp_o), 256'd0);
    chk("b2b.idle_read_o", 256'(read_o), 256'd0);
    @(negedge clk);
    chk("b2b.read_o", 256'(read_o), 256'd1);
    chk("b2b.address_o", 256'(address_o), 256'h40);
    // Two beats, then asynchronous reset mid-burst
    for (int b = 0; b < 2; b++) begin
      resp_i = 1'b1; burst_i = 64'hDEAD_0000_0000_0000 | 64'(b);
      @(negedge clk);
    end
    resp_i = 1'b0;
    rst = 1'b1;
    #1;
    chk_idle_outputs("async_rst");
    @(negedge clk);
    rst = 1'b0;
    beats[0] = 64'h5555_5555_5555_5555; beats[1] = 64'h6666_6666_6666_6666;
    beats[2] = 64'h7777_7777_7777_7777; beats[3] = 64'h8888_8888_8888_8888;
    address_i = 32'h0000_ABCF;
    exp_line_q.push_back({beats[3], beats[2], beats[1], beats[0]});
    @(negedge clk);
    chk("post_rst.read_o", 256'(read_o), 256'd1);
    chk("post_rst.address_o", 256'(address_o), 256'hABC0);
    read_i = 1'b0;
    for (int b = 0; b < 4; b++) begin
      resp_i = 1'b1; burst_i = beats[b];
      @(negedge clk);
    end
    resp_i = 1'b0;
    chk("post_rst.resp_o", 256'(resp_o), 256'd1);
    chk("post_rst.line_o", line_o, exp_line_q.pop_front());
    held = line_o;
    @(negedge clk);

    // Gapped writeback with read_i also high: write wins
    line_i = {64'hDDDD_0000_0000_000D, 64'hCCCC_0000_0000_000C,
              64'hBBBB_0000_0000_000B, 64'hAAAA_0000_0000_000A};
    for (int b = 0; b < 4; b++) exp_beat_q.push_back(line_i[b*64 +: 64]);
    address_i = 32'h0000_2001; write_i = 1'b1; read_i = 1'b1;
    @(negedge clk);
    line_i = '0;
    chk("wr.write_o", 256'(write_o), 256'd1);
    chk("wr.read_o", 256'(read_o), 256'd0);
    chk("wr.address_o", 256'(address_o), 256'h2000);
    cur = exp_beat_q.pop_front();
    chk("wr.burst0", 256'(burst_o), 256'(cur));
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    k = 0;
    for (int i = 0; i < 6; i++) begin
      resp_i = pat[i];
      @(negedge clk);
      if (pat[i]) k++;
      if (k < 4) begin
        if (pat[i]) cur = exp_beat_q.pop_front();
        chk($sformatf("wr.burst_step%0d", i), 256'(burst_o), 256'(cur));
        chk($sformatf("wr.write_hold%0d", i), 256'(write_o), 256'd1);
      end
    end
    resp_i = 1'b0; write_i = 1'b0; read_i = 1'b0;
    chk("wr.resp_o", 256'(resp_o), 256'd1);
    chk("wr.write_o_drop", 256'(write_o), 256'd0);
    chk("wr.line_o_untouched", line_o, held);
    @(negedge clk);
    chk("wr.resp_pulse", 256'(resp_o), 256'd0);
    // Acknowledges while idle are ignored
    resp_i = 1'b1; burst_i = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    resp_i = 1'b0;
    chk("idle.resp_ignored", line_o, held);

    // Stalled read: no acknowledges
    address_i = 32'h0000_3000; read_i = 1'b1;
    @(negedge clk);
    read_i = 1'b0;
    k = 0; seen = 1'b0;
    while (k < 300 && !seen) begin
      @(negedge clk);
      k++;
      if (resp_o) seen = 1'b1;
    end
`ifdef LINE_BURST_TIMEOUT_EN
    chk("tmo.latency", 256'(k), 256'd255);
    chk("tmo.err_o", 256'(err_o), 256'd1);
    chk("tmo.line_o_partial", line_o, held);
    @(negedge clk);
    chk("tmo.err_pulse", 256'(err_o), 256'd0);
`else
    chk("stall.no_resp", 256'(seen), 256'd0);
    chk("stall.read_o", 256'(read_o), 256'd1);
    chk("stall.err_o", 256'(err_o), 256'd0);
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
